// File: rtl/seg_msg_pkg.sv
// Shared types and glyph constants for the seven-segment message sequencer.
// Glyphs are active-high, bit 0 = segment a through bit 6 = segment g.
package seg_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2,
    ST_GAP   = 2'd3
  } seg_state_e;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_H = 7'h76;
  localparam logic [6:0] GLYPH_L = 7'h38;
  localparam logic [6:0] GLYPH_P = 7'h73;
  localparam logic [6:0] GLYPH_S = 7'h6D;

endpackage

// File: rtl/seg_tick_timer.sv
// Loadable down-counter timing every SHOW/BLANK/GAP interval.
// Loading N-1 makes expired_o rise after N cycles in the new state.
module seg_tick_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/seg_msg_sequencer.sv
// Plays a stored glyph message on a segment display with on/blank/gap timing.
// Define SEG_MSG_ACTIVE_LOW_EN for common-anode displays (inverted seg_out).
module seg_msg_sequencer
  import seg_msg_pkg::*;
#(
  parameter  int MAX_CHARS = 8,
  parameter  int CNT_W     = 16,
  parameter  int SEG_W     = 7,
  localparam int IDX_W     = $clog2(MAX_CHARS),
  localparam int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [CNT_W-1:0] on_ticks,
  input  logic [CNT_W-1:0] off_ticks,
  input  logic [CNT_W-1:0] gap_ticks,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  output logic [SEG_W-1:0] seg_out,
  output logic [IDX_W-1:0] char_idx,
  output logic             busy,
  output logic             done
);

`ifdef SEG_MSG_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] POL_MASK = '1;
`else
  localparam logic [SEG_W-1:0] POL_MASK = '0;
`endif
  localparam logic [SEG_W-1:0] BLANK_INT = SEG_W'(GLYPH_BLANK);
  localparam logic [SEG_W-1:0] BLANK_OUT = BLANK_INT ^ POL_MASK;

  seg_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_in, show_idx;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             done_q, done_d;
  logic             one_shot_q;
  logic [CNT_W-1:0] on_q, off_q, gap_q, on_src, on_load, tmr_val;
  logic             tmr_load, tmr_expired;
  logic             accept, glyph_done, msg_done, show_next;
  logic [LEN_W-1:0] len_clamped;
  logic [SEG_W-1:0] table_q [MAX_CHARS];

  assign len_clamped = (32'(msg_len) > MAX_CHARS) ? LEN_W'(MAX_CHARS) : msg_len;
  assign last_in     = IDX_W'(len_clamped - LEN_W'(1));
  assign on_src      = (state_q == ST_IDLE) ? on_ticks : on_q;
  assign on_load     = (on_src == '0) ? '0 : on_src - CNT_W'(1);

  // NOTE: the table must read blank after reset, so it is built from
  // resettable flops instead of an uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) table_q[i] <= BLANK_INT;
    end else if (wr_en && (32'(wr_addr) < MAX_CHARS)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  seg_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seg_d      = seg_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    accept     = 1'b0;
    glyph_done = 1'b0;
    msg_done   = 1'b0;
    show_next  = 1'b0;
    show_idx   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (msg_len != '0)) begin
          accept    = 1'b1;
          show_next = 1'b1;
        end
      end
      ST_SHOW: begin
        if (tmr_expired) begin
          if (off_q != '0) begin
            state_d  = ST_BLANK;
            seg_d    = BLANK_OUT;
            tmr_load = 1'b1;
            tmr_val  = off_q - CNT_W'(1);
          end else begin
            glyph_done = 1'b1;
          end
        end
      end
      ST_BLANK: glyph_done = tmr_expired;
      ST_GAP:   msg_done   = tmr_expired;
      default:  state_d    = ST_IDLE;
    endcase

    if (glyph_done) begin
      if (idx_q != last_q) begin
        show_next = 1'b1;
        show_idx  = idx_q + IDX_W'(1);
      end else if (gap_q != '0) begin
        state_d  = ST_GAP;
        seg_d    = BLANK_OUT;
        tmr_load = 1'b1;
        tmr_val  = gap_q - CNT_W'(1);
      end else begin
        msg_done = 1'b1;
      end
    end

    if (msg_done) begin
      if (one_shot_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        seg_d   = BLANK_OUT;
        done_d  = 1'b1;
      end else begin
        show_next = 1'b1;
      end
    end

    // Glyph is fetched here, on SHOW entry, so table writes land on the next visit.
    if (show_next) begin
      state_d  = ST_SHOW;
      idx_d    = show_idx;
      seg_d    = table_q[show_idx] ^ POL_MASK;
      tmr_load = 1'b1;
      tmr_val  = on_load;
    end

    if (stop) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      seg_d    = BLANK_OUT;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      seg_q      <= BLANK_OUT;
      done_q     <= 1'b0;
      last_q     <= '0;
      one_shot_q <= 1'b0;
      on_q       <= '0;
      off_q      <= '0;
      gap_q      <= '0;
    end else begin
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      done_q <= done_d;
      if (accept) begin
        last_q     <= last_in;
        one_shot_q <= one_shot;
        on_q       <= on_ticks;
        off_q      <= off_ticks;
        gap_q      <= gap_ticks;
      end
    end
  end

  assign seg_out  = seg_q;
  assign char_idx = idx_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench for seg_msg_sequencer: vector table plus multi-cycle sequences.
// Expected glyphs are logical values, inverted when SEG_MSG_ACTIVE_LOW_EN is set.
module tb_seg_msg_sequencer;
  import seg_msg_pkg::*;

  localparam int MAX_CHARS = 8;
  localparam int CNT_W     = 16;
  localparam int SEG_W     = 7;
  localparam int IDX_W     = $clog2(MAX_CHARS);
  localparam int LEN_W     = $clog2(MAX_CHARS + 1);

`ifdef SEG_MSG_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] POL = '1;
`else
  localparam logic [SEG_W-1:0] POL = '0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, one_shot = 1'b0, wr_en = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [CNT_W-1:0] on_ticks = '0, off_ticks = '0, gap_ticks = '0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [SEG_W-1:0] wr_data = '0;
  logic [SEG_W-1:0] seg_out;
  logic [IDX_W-1:0] char_idx;
  logic             busy, done;

  int checks = 0;
  int failures = 0;

  seg_msg_sequencer #(.MAX_CHARS(MAX_CHARS), .CNT_W(CNT_W), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .one_shot  (one_shot),
    .msg_len   (msg_len),
    .on_ticks  (on_ticks),
    .off_ticks (off_ticks),
    .gap_ticks (gap_ticks),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seg_out   (seg_out),
    .char_idx  (char_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               start;
    bit               stop;
    bit               perturb;
    logic [SEG_W-1:0] seg;
    int               idx;
    bit               busy;
    bit               done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [SEG_W-1:0] e_seg, input int e_idx,
                            input bit e_busy, input bit e_done);
    check({name, ".seg"},  32'(seg_out),  32'(e_seg ^ POL));
    check({name, ".idx"},  32'(char_idx), 32'(e_idx));
    check({name, ".busy"}, 32'(busy),     32'(e_busy));
    check({name, ".done"}, 32'(done),     32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input int len, input int on, input int off, input int gap, input bit os);
    msg_len   = LEN_W'(len);
    on_ticks  = CNT_W'(on);
    off_ticks = CNT_W'(off);
    gap_ticks = CNT_W'(gap);
    one_shot  = os;
  endtask

  task automatic write_glyph(input int addr, input logic [SEG_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic add_rep(input int n, input bit s, input bit st, input bit p,
                         input logic [SEG_W-1:0] sg, input int ix, input bit b, input bit d);
    for (int k = 0; k < n; k++) vecs.push_back('{s, st, p, sg, ix, b, d});
  endtask

  initial begin
    logic [SEG_W-1:0] full_tbl [MAX_CHARS];
    logic [IDX_W-1:0] last_idx;
    int               seq[$];
    int               dones;

    full_tbl = '{GLYPH_E, GLYPH_C, GLYPH_L, GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4};

    // Phase A: one-shot E/C/L, params perturbed and start re-asserted mid-play.
    add_rep(1, 1, 0, 0, GLYPH_E,     0, 1, 0);
    add_rep(2, 0, 0, 1, GLYPH_E,     0, 1, 0);
    add_rep(2, 0, 0, 0, GLYPH_BLANK, 0, 1, 0);
    add_rep(1, 0, 0, 0, GLYPH_C,     1, 1, 0);
    add_rep(1, 1, 0, 0, GLYPH_C,     1, 1, 0);
    add_rep(1, 0, 0, 0, GLYPH_C,     1, 1, 0);
    add_rep(2, 0, 0, 0, GLYPH_BLANK, 1, 1, 0);
    add_rep(3, 0, 0, 0, GLYPH_L,     2, 1, 0);
    add_rep(2, 0, 0, 0, GLYPH_BLANK, 2, 1, 0);
    add_rep(4, 0, 0, 0, GLYPH_BLANK, 2, 1, 0);
    add_rep(1, 0, 0, 0, GLYPH_BLANK, 0, 0, 1);
    add_rep(1, 0, 0, 0, GLYPH_BLANK, 0, 0, 0);
    // Phase B: stop in the 2nd SHOW cycle of glyph 1, then start+stop together.
    add_rep(3, 0, 0, 0, GLYPH_E,     0, 1, 0);
    vecs[vecs.size()-3].start = 1'b1;
    add_rep(2, 0, 0, 0, GLYPH_BLANK, 0, 1, 0);
    add_rep(2, 0, 0, 0, GLYPH_C,     1, 1, 0);
    add_rep(1, 0, 1, 0, GLYPH_BLANK, 0, 0, 0);
    add_rep(1, 0, 0, 0, GLYPH_BLANK, 0, 0, 0);
    add_rep(1, 1, 1, 0, GLYPH_BLANK, 0, 0, 0);
    add_rep(1, 0, 0, 0, GLYPH_BLANK, 0, 0, 0);

    // Reset state.
    tick();
    check_outs("reset", GLYPH_BLANK, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    write_glyph(0, GLYPH_E);
    write_glyph(1, GLYPH_C);
    write_glyph(2, GLYPH_L);

    foreach (vecs[i]) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      if (vecs[i].perturb) set_params(1, 7, 0, 0, 0);
      else                 set_params(3, 3, 2, 4, 1);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].seg, vecs[i].idx, vecs[i].busy, vecs[i].done);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Looping playback: idx 0,1,2 repeated three times, done never pulses.
    set_params(3, 3, 2, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    seq.push_back(int'(char_idx));
    last_idx = char_idx;
    dones = int'(done);
    for (int i = 1; i < 57; i++) begin
      tick();
      if (char_idx != last_idx) begin
        seq.push_back(int'(char_idx));
        last_idx = char_idx;
      end
      if (done) dones++;
      if (i == 19) check_outs("loop_wrap", GLYPH_E, 0, 1, 0);
    end
    check("loop_seq_len", 32'(seq.size()), 32'd9);
    for (int k = 0; k < 9; k++)
      check($sformatf("loop_seq%0d", k), 32'((k < seq.size()) ? seq[k] : -1), 32'(k % 3));
    check("loop_done_count", 32'(dones), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outs("loop_stop", GLYPH_BLANK, 0, 0, 0);

    // Zero timing: one glyph per cycle.
    set_params(2, 0, 0, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("fast0", GLYPH_E, 0, 1, 0);
    tick();
    check_outs("fast1", GLYPH_C, 1, 1, 0);
    tick();
    check_outs("fast_end", GLYPH_BLANK, 0, 0, 1);

    // msg_len = 0 ignores start.
    set_params(0, 3, 2, 4, 1);
    start = 1'b1;
    tick();
    check("len0_busy_a", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("len0_busy_b", 32'(busy), 32'd0);

    // msg_len = 12 clamps to 8 glyphs.
    for (int a = 3; a < MAX_CHARS; a++) write_glyph(a, full_tbl[a]);
    set_params(12, 0, 0, 0, 1);
    start = 1'b1;
    for (int i = 0; i < MAX_CHARS; i++) begin
      tick();
      start = 1'b0;
      check_outs($sformatf("clamp%0d", i), full_tbl[i], i, 1, 0);
    end
    tick();
    check_outs("clamp_end", GLYPH_BLANK, 0, 0, 1);

    // Asynchronous reset mid-BLANK.
    set_params(3, 3, 2, 4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check_outs("pre_rst_blank", GLYPH_BLANK, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", GLYPH_BLANK, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_params(3, 1, 0, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("rst_tbl0", GLYPH_BLANK, 0, 1, 0);
    tick();
    check_outs("rst_tbl1", GLYPH_BLANK, 1, 1, 0);
    tick();
    check_outs("rst_tbl2", GLYPH_BLANK, 2, 1, 0);
    tick();
    check_outs("rst_tbl_end", GLYPH_BLANK, 0, 0, 1);

    // Write to table[1] while glyph 0 is showing.
    write_glyph(0, GLYPH_E);
    write_glyph(1, GLYPH_C);
    write_glyph(2, GLYPH_L);
    set_params(3, 3, 2, 4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("live_g0", GLYPH_E, 0, 1, 0);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(1);
    wr_data = GLYPH_S;
    tick();
    wr_en = 1'b0;
    repeat (4) tick();
    check_outs("live_g1", GLYPH_S, 1, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outs("live_stop", GLYPH_BLANK, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_msg_sequencer.md
SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 8, giving glyph table depth (range 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the tick-duration fields.
REQ-003 SHALL have parameter SEG_W, default 7, giving the segment bus width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin playback; level sampled each cycle.
REQ-008 stop  input  1  abort playback.
REQ-009 one_shot  input  1  1 = play message once, 0 = loop.
REQ-010 msg_len  input  clog2(MAX_CHARS+1)  number of glyphs to play.
REQ-011 on_ticks, off_ticks, gap_ticks  input  CNT_W each  glyph-on, inter-glyph blank and end-of-message gap durations in cycles.
REQ-012 wr_en, wr_addr (clog2(MAX_CHARS)), wr_data (SEG_W)  input  glyph table write port.
REQ-013 seg_out  output  SEG_W  registered segment drive.
REQ-014 char_idx  output  clog2(MAX_CHARS)  index of the current glyph.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at one-shot completion.

Function
REQ-017 FSM states SHALL be IDLE, SHOW, BLANK and GAP.
REQ-018 IDLE: start=1, stop=0, msg_len!=0 -> SHOW with char_idx=0; seg_out=table[0] on the following edge.
REQ-019 msg_len, one_shot and the three tick fields SHALL be latched on accepting start; later changes SHALL be ignored until the next IDLE.
REQ-020 msg_len > MAX_CHARS SHALL be clamped to MAX_CHARS; msg_len=0 SHALL cause start to be ignored.
REQ-021 SHOW SHALL last max(on_ticks,1) cycles; then -> BLANK, or straight to the next glyph if off_ticks=0.
REQ-022 BLANK SHALL drive the blank pattern for off_ticks cycles, then advance char_idx and enter SHOW.
REQ-023 After the last glyph's blank, GAP SHALL drive blank for gap_ticks cycles (skipped if 0).
REQ-024 End of GAP: one_shot=1 -> pulse done, go to IDLE; one_shot=0 -> char_idx wraps to 0 and enters SHOW.
REQ-025 The glyph SHALL be read from the table on SHOW entry; writes during playback SHALL take effect on the next read of that address.
REQ-026 stop=1 in any state SHALL return to IDLE next edge with seg_out blank and char_idx=0; done SHALL NOT pulse.
REQ-027 If start and stop are both 1, stop SHALL win; start while busy SHALL be ignored.
REQ-028 A write with wr_addr >= MAX_CHARS SHALL be discarded.

Reset
REQ-029 Reset SHALL force IDLE, seg_out=blank, char_idx=0, busy=0, done=0, all table entries=blank, and clear the tick counter.
REQ-030 Reset asserted mid-playback SHALL abort immediately; no done pulse.

Configuration
REQ-031 Macro SEG_MSG_ACTIVE_LOW_EN defined: seg_out and the blank pattern SHALL be bitwise inverted (blank = all ones) for common-anode displays.
REQ-032 Macro SEG_MSG_ACTIVE_LOW_EN absent: seg_out SHALL be active-high (blank = all zeros).

Structure
REQ-033 Package seg_msg_pkg SHALL hold the state enum, the GLYPH_BLANK constant and named letter/digit glyph constants.
REQ-034 A sub-module seg_tick_timer (loadable down-counter, CNT_W wide, expire flag) SHALL time all SHOW/BLANK/GAP intervals.

Verification
REQ-035 Table = {0x79,0x39,0x38}, msg_len=3, on=3, off=2, gap=4, one_shot=1 -> exact 3/2-cycle glyph/blank pattern, 4-cycle gap, done pulses once, busy falls on the same edge.
REQ-036 Same setup with one_shot=0 -> char_idx sequence 0,1,2,0,... across 3 loops; done never asserts.
REQ-037 stop asserted in the 2nd SHOW cycle of glyph 1 -> IDLE next edge, seg_out=blank; start and stop together -> stays IDLE.
REQ-038 on=0, off=0, gap=0, msg_len=2 -> glyph changes every cycle; msg_len=0 -> start ignored; msg_len=12 with MAX_CHARS=8 -> plays 8 glyphs.
REQ-039 rst_n pulled low mid-BLANK -> outputs at reset values asynchronously; table reads blank afterwards.
REQ-040 Write table[1]=0x6D during glyph 0 -> glyph 1 shows 0x6D; run with SEG_MSG_ACTIVE_LOW_EN -> outputs inverted and blank reads 0x7F.
